// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: round-robin sequencer in front of a shared 4-bit ALU.
// Two requesters present W = 4*NIB bit operations. The winner's operation is
// run as NIB back-to-back nibble passes, LSB first, and the carry is chained
// between passes for add. The assembled result is returned with the
// requester id.
// Optional build macro ALU_SEQ_ERR_EN: when defined, opcodes other than
// add/OR/AND bypass the ALU and return an error response one cycle after the
// grant. When undefined, every opcode runs through the ALU and resp_err is 0.
module alu_seq_ctrl #(
  parameter int NIB = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [2:0]       req0_op,
  input  logic [4*NIB-1:0] req0_a,
  input  logic [4*NIB-1:0] req0_b,
  input  logic             req0_cin,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [2:0]       req1_op,
  input  logic [4*NIB-1:0] req1_a,
  input  logic [4*NIB-1:0] req1_b,
  input  logic             req1_cin,
  output logic [3:0]       alu_a,
  output logic [3:0]       alu_b,
  output logic [2:0]       alu_ctrl,
  output logic             alu_cin,
  input  logic [3:0]       alu_out,
  input  logic             alu_cout,
  output logic             resp_valid,
  output logic             resp_id,
  output logic [4*NIB-1:0] resp_data,
  output logic             resp_cout,
  output logic             resp_err,
  output logic             busy
);

  localparam int         W      = 4 * NIB;
  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [3:0] K_LAST = 4'(NIB - 1);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t         state_q;
  logic   [3:0]   k_q;
  logic           last_grant_q;

  logic   [2:0]   op_q;
  logic   [W-1:0] a_q;
  logic   [W-1:0] b_q;
  logic   [W-1:0] res_q;
  logic   [W-1:0] res_d;
  logic           id_q;

  logic   [3:0]   alu_a_q;
  logic   [3:0]   alu_b_q;
  logic   [2:0]   alu_ctrl_q;
  logic           alu_cin_q;

  logic           resp_valid_q;
  logic           resp_id_q;
  logic   [W-1:0] resp_data_q;
  logic           resp_cout_q;

  logic           any_valid;
  logic           pick1;
  logic           grant;
  logic   [2:0]   sel_op;
  logic   [W-1:0] sel_a;
  logic   [W-1:0] sel_b;
  logic           sel_cin;
  logic   [3:0]   k_nxt;

`ifdef ALU_SEQ_ERR_EN
  logic           resp_err_q;

  function automatic logic op_supported(input logic [2:0] op);
    return (op == 3'b000) || (op == 3'b010) || (op == 3'b011);
  endfunction
`endif

  // Round-robin pick: favour the requester that did not win last time; the
  // grant is suppressed while rst is high so an aborted request sees no ready.
  always_comb begin
    any_valid = req0_valid | req1_valid;
    pick1     = last_grant_q ? (req1_valid & ~req0_valid) : req1_valid;
    grant     = (state_q == IDLE) & ~rst & any_valid;
    sel_op    = pick1 ? req1_op  : req0_op;
    sel_a     = pick1 ? req1_a   : req0_a;
    sel_b     = pick1 ? req1_b   : req0_b;
    sel_cin   = pick1 ? req1_cin : req0_cin;
  end

  assign req0_ready = grant & ~pick1;
  assign req1_ready = grant &  pick1;

  // Result with the current pass's nibble merged in; feeds both the
  // accumulator and the final response so the last nibble needs no extra cycle.
  always_comb begin
    res_d                   = res_q;
    res_d[{k_q, 2'b00} +: 4] = alu_out;
    k_nxt                   = k_q + 4'd1;
  end

  // Operand capture and nibble accumulation; data path carries no reset.
  always_ff @(posedge clk) begin
    if (grant) begin
      op_q <= sel_op;
      a_q  <= sel_a;
      b_q  <= sel_b;
      id_q <= pick1;
    end
    if (state_q == EXEC) begin
      res_q <= res_d;
    end
  end

  // Control FSM with registered ALU drive and response outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      k_q          <= '0;
      last_grant_q <= 1'b1;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_ctrl_q   <= '0;
      alu_cin_q    <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_id_q    <= 1'b0;
      resp_data_q  <= '0;
      resp_cout_q  <= 1'b0;
`ifdef ALU_SEQ_ERR_EN
      resp_err_q   <= 1'b0;
`endif
    end else begin
      resp_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (grant) begin
            last_grant_q <= pick1;
            k_q          <= '0;
`ifdef ALU_SEQ_ERR_EN
            if (!op_supported(sel_op)) begin
              state_q      <= RESP;
              resp_valid_q <= 1'b1;
              resp_id_q    <= pick1;
              resp_data_q  <= '0;
              resp_cout_q  <= 1'b0;
              resp_err_q   <= 1'b1;
            end else begin
              state_q    <= EXEC;
              alu_a_q    <= sel_a[3:0];
              alu_b_q    <= sel_b[3:0];
              alu_ctrl_q <= sel_op;
              alu_cin_q  <= (sel_op == OP_ADD) & sel_cin;
            end
`else
            state_q    <= EXEC;
            alu_a_q    <= sel_a[3:0];
            alu_b_q    <= sel_b[3:0];
            alu_ctrl_q <= sel_op;
            alu_cin_q  <= (sel_op == OP_ADD) & sel_cin;
`endif
          end
        end
        EXEC: begin
          if (k_q == K_LAST) begin
            state_q      <= RESP;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_ctrl_q   <= '0;
            alu_cin_q    <= 1'b0;
            resp_valid_q <= 1'b1;
            resp_id_q    <= id_q;
            resp_data_q  <= res_d;
            resp_cout_q  <= (op_q == OP_ADD) & alu_cout;
`ifdef ALU_SEQ_ERR_EN
            resp_err_q   <= 1'b0;
`endif
          end else begin
            k_q       <= k_nxt;
            alu_a_q   <= a_q[{k_nxt, 2'b00} +: 4];
            alu_b_q   <= b_q[{k_nxt, 2'b00} +: 4];
            alu_cin_q <= (op_q == OP_ADD) & alu_cout;
          end
        end
        RESP: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_ctrl   = alu_ctrl_q;
  assign alu_cin    = alu_cin_q;
  assign resp_valid = resp_valid_q;
  assign resp_id    = resp_id_q;
  assign resp_data  = resp_data_q;
  assign resp_cout  = resp_cout_q;
  assign busy       = (state_q != IDLE);

`ifdef ALU_SEQ_ERR_EN
  assign resp_err = resp_err_q;
`else
  assign resp_err = 1'b0;
`endif

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Testbench for alu_seq_ctrl (NIB = 2) with a behavioural 4-bit ALU attached.
module tb_alu_seq_ctrl;

  localparam int NIB = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0_valid, req0_ready, req0_cin;
  logic [2:0] req0_op;
  logic [7:0] req0_a, req0_b;
  logic       req1_valid, req1_ready, req1_cin;
  logic [2:0] req1_op;
  logic [7:0] req1_a, req1_b;
  logic [3:0] alu_a, alu_b, alu_out;
  logic [2:0] alu_ctrl;
  logic       alu_cin, alu_cout;
  logic       resp_valid, resp_id, resp_cout, resp_err, busy;
  logic [7:0] resp_data;

  always #5 clk = ~clk;

  alu_seq_ctrl #(.NIB(NIB)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b), .req0_cin(req0_cin),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b), .req1_cin(req1_cin),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl), .alu_cin(alu_cin),
    .alu_out(alu_out), .alu_cout(alu_cout),
    .resp_valid(resp_valid), .resp_id(resp_id), .resp_data(resp_data),
    .resp_cout(resp_cout), .resp_err(resp_err), .busy(busy)
  );

  // Shared combinational ALU
  always_comb begin
    alu_out  = 4'h0;
    alu_cout = 1'b0;
    case (alu_ctrl)
      3'b000:  {alu_cout, alu_out} = {1'b0, alu_a} + {1'b0, alu_b} + {4'b0, alu_cin};
      3'b010:  alu_out = alu_a | alu_b;
      3'b011:  alu_out = alu_a & alu_b;
      default: alu_out = alu_a ^ alu_b;
    endcase
  end

  typedef struct {
    bit         id;
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    bit         cin;
    logic [7:0] exp_data;
    bit         exp_cout;
    bit         exp_err;
    int         exp_lat;
    bit         exp_c0;
    bit         exp_c1;
  } vec_t;

  vec_t vecs[8];

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input bit id, input logic [2:0] op, input logic [7:0] a,
                           input logic [7:0] b, input bit cin);
    if (id) begin
      req1_op = op; req1_a = a; req1_b = b; req1_cin = cin; req1_valid = 1'b1;
    end else begin
      req0_op = op; req0_a = a; req0_b = b; req0_cin = cin; req0_valid = 1'b1;
    end
  endtask

  // Waits (bounded) for the given requester's ready; returns in that cycle.
  task automatic wait_ready(input bit id, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 20 && !ok; n++) begin
      #1;
      if (id ? req1_ready : req0_ready) ok = 1'b1;
      else tick();
    end
  endtask

  // Called one cycle after the grant; counts cycles until resp_valid.
  task automatic wait_resp(output int lat, output bit got, output bit c0, output bit c1);
    lat = 1; got = 1'b0; c0 = 1'b0; c1 = 1'b0;
    for (int n = 0; n < 20 && !got; n++) begin
      #1;
      if (lat == 1) c0 = alu_cin;
      if (lat == 2) c1 = alu_cin;
      if (resp_valid) got = 1'b1;
      else begin
        tick();
        lat++;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit   ok, got, c0, c1, both_seen;
    int   lat, ng, nr, cyc;
    bit   gid[4];
    int   gt[4];
    bit   rid[4];
    logic [7:0] rdat[4];

    //            id  op      a      b      cin data   cout err lat c0 c1
    vecs[0] = '{1'b0, 3'b000, 8'h3C, 8'h5A, 1'b0, 8'h96, 1'b0, 1'b0, 3, 1'b0, 1'b1};
    vecs[1] = '{1'b1, 3'b000, 8'hF0, 8'h20, 1'b1, 8'h11, 1'b1, 1'b0, 3, 1'b1, 1'b0};
    vecs[2] = '{1'b0, 3'b010, 8'hA5, 8'h0F, 1'b0, 8'hAF, 1'b0, 1'b0, 3, 1'b0, 1'b0};
    vecs[3] = '{1'b0, 3'b011, 8'hA5, 8'h0F, 1'b0, 8'h05, 1'b0, 1'b0, 3, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 3'b000, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 3, 1'b0, 1'b1};
    vecs[5] = '{1'b0, 3'b000, 8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0, 3, 1'b0, 1'b1};
    vecs[6] = '{1'b1, 3'b011, 8'h5A, 8'h3C, 1'b1, 8'h18, 1'b0, 1'b0, 3, 1'b0, 1'b0};
`ifdef ALU_SEQ_ERR_EN
    vecs[7] = '{1'b1, 3'b101, 8'h3C, 8'h5A, 1'b0, 8'h00, 1'b0, 1'b1, 1, 1'b0, 1'b0};
`else
    vecs[7] = '{1'b1, 3'b101, 8'h3C, 8'h5A, 1'b0, 8'h66, 1'b0, 1'b0, 3, 1'b0, 1'b0};
`endif

    rst = 1'b1;
    req0_valid = 1'b1; req0_op = 3'b000; req0_a = 8'h00; req0_b = 8'h00; req0_cin = 1'b0;
    req1_valid = 1'b0; req1_op = 3'b000; req1_a = 8'h00; req1_b = 8'h00; req1_cin = 1'b0;

    // Reset state, with a request held to confirm ready stays low under rst
    repeat (3) tick();
    #1;
    chk("rst_ready0", req0_ready, 0);
    chk("rst_ready1", req1_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_data", resp_data, 0);
    chk("rst_resp_err", resp_err, 0);
    chk("rst_alu", {alu_a, alu_b, alu_ctrl, alu_cin}, 0);
    tick();
    req0_valid = 1'b0;
    rst = 1'b0;

    // Table-driven single operations
    for (int i = 0; i < 8; i++) begin
      drive_req(vecs[i].id, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].cin);
      wait_ready(vecs[i].id, ok);
      chk($sformatf("v%0d_ready", i), ok, 1);
      chk($sformatf("v%0d_other_ready", i), vecs[i].id ? req0_ready : req1_ready, 0);
      tick();
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      wait_resp(lat, got, c0, c1);
      chk($sformatf("v%0d_resp_seen", i), got, 1);
      chk($sformatf("v%0d_latency", i), lat, vecs[i].exp_lat);
      chk($sformatf("v%0d_data", i), resp_data, vecs[i].exp_data);
      chk($sformatf("v%0d_cout", i), resp_cout, vecs[i].exp_cout);
      chk($sformatf("v%0d_id", i), resp_id, vecs[i].id);
      chk($sformatf("v%0d_err", i), resp_err, vecs[i].exp_err);
      chk($sformatf("v%0d_alu_idle", i), {alu_a, alu_b, alu_ctrl, alu_cin}, 0);
      if (vecs[i].exp_lat == 3) begin
        chk($sformatf("v%0d_alu_cin_k0", i), c0, vecs[i].exp_c0);
        chk($sformatf("v%0d_alu_cin_k1", i), c1, vecs[i].exp_c1);
      end
      tick();
      #1;
      chk($sformatf("v%0d_valid_1cyc", i), resp_valid, 0);
      chk($sformatf("v%0d_data_hold", i), resp_data, vecs[i].exp_data);
    end

    // Both requesters continuously valid: grants alternate 0,1,0,1
    drive_req(1'b0, 3'b000, 8'h01, 8'h01, 1'b0);
    drive_req(1'b1, 3'b000, 8'h02, 8'h02, 1'b0);
    ng = 0; nr = 0; cyc = 0; both_seen = 1'b0;
    for (int n = 0; n < 60 && nr < 4; n++) begin
      #1;
      if (req0_ready && req1_ready) both_seen = 1'b1;
      if (req0_ready || req1_ready) begin
        if (ng < 4) begin
          gid[ng] = req1_ready;
          gt[ng]  = cyc;
        end
        ng++;
      end
      if (resp_valid) begin
        rid[nr]  = resp_id;
        rdat[nr] = resp_data;
        nr++;
      end
      tick();
      cyc++;
      if (ng >= 4) begin
        req0_valid = 1'b0;
        req1_valid = 1'b0;
      end
    end
    chk("arb_grants", ng, 4);
    chk("arb_resps", nr, 4);
    chk("arb_both_ready", both_seen, 0);
    if (ng == 4 && nr == 4) begin
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("arb_grant%0d_id", i), gid[i], i % 2);
        chk($sformatf("arb_resp%0d_id", i), rid[i], i % 2);
        chk($sformatf("arb_resp%0d_data", i), rdat[i], (i % 2) ? 8'h04 : 8'h02);
        if (i > 0) chk($sformatf("arb_gap%0d", i), gt[i] - gt[i-1], 4);
      end
    end

    // rst during EXEC k=1 aborts; held req0 is re-granted after rst
    drive_req(1'b0, 3'b000, 8'h11, 8'h22, 1'b0);
    wait_ready(1'b0, ok);
    chk("abort_first_ready", ok, 1);
    tick();
    req0_valid = 1'b1;
    tick();
    rst = 1'b1;
    drive_req(1'b1, 3'b000, 8'h01, 8'h01, 1'b0);
    #1;
    chk("abort_busy_k1", busy, 1);
    chk("abort_no_ready_exec", req0_ready | req1_ready, 0);
    tick();
    rst = 1'b0;
    #1;
    chk("abort_no_resp", resp_valid, 0);
    chk("abort_idle", busy, 0);
    chk("abort_regrant_req0", req0_ready, 1);
    chk("abort_regrant_not_req1", req1_ready, 0);
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    wait_resp(lat, got, c0, c1);
    chk("abort_resp_seen", got, 1);
    chk("abort_resp_latency", lat, 3);
    chk("abort_resp_data", resp_data, 8'h33);
    chk("abort_resp_id", resp_id, 0);
    tick();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/alu_seq_ctrl.md
Name: alu_seq_ctrl

Overview:
- Sequencer and arbiter in front of the shared 4-bit combinational ALU (ports A, B, Control, Cin -> ALU_output, Cout).
- Accepts multi-nibble operations from two requesters and arbitrates between them round-robin.
- Runs each operation as NIB back-to-back 4-bit passes, LSB nibble first, chaining carry between passes.
- Returns the assembled result with the requester id.

Parameters:
- NIB, 2, operand width in nibbles; operand width W = 4*NIB; legal range 1..8.

Ports:
- clk  input  1  sole clock, rising edge
- rst  input  1  synchronous, active-high reset
- req0_valid  input  1  requester 0 has an operation pending
- req0_ready  output  1  requester 0 operation accepted this cycle
- req0_op  input  3  ALU control code
- req0_a  input  W  operand A
- req0_b  input  W  operand B
- req0_cin  input  1  carry-in
- req1_valid / req1_ready / req1_op / req1_a / req1_b / req1_cin: same as requester 0, for requester 1
- alu_a  output  4  to ALU A
- alu_b  output  4  to ALU B
- alu_ctrl  output  3  to ALU Control
- alu_cin  output  1  to ALU Cin
- alu_out  input  4  from ALU ALU_output
- alu_cout  input  1  from ALU Cout
- resp_valid  output  1  one-cycle result strobe
- resp_id  output  1  requester that owns the result
- resp_data  output  W  result
- resp_cout  output  1  final carry (add only, else 0)
- resp_err  output  1  unsupported opcode flag
- busy  output  1  high in any state other than IDLE

Behaviour:
- Decided: one clock, clk; rst is synchronous, active-high, sampled on the rising edge.
- Reset values:
  - state = IDLE; nibble counter = 0; last_grant = 1, so requester 0 wins first.
  - All ready, resp_* and busy outputs = 0; alu_a, alu_b, alu_ctrl, alu_cin = 0.
- rst asserted mid-operation aborts the operation: no resp_valid and no ready for the aborted request. Requesters must re-present.
- States:
  - IDLE -> EXEC when any reqX_valid is high.
    - Grant goes to the requester not equal to last_grant if it is valid, else to the other one.
    - reqX_ready pulses 1 cycle for the winner; op, a, b and cin are captured; last_grant is updated.
    - Ready is never high for both requesters in the same cycle. The loser holds valid and is served next.
  - EXEC: nibble counter k runs 0..NIB-1, one ALU pass per cycle.
    - alu_a = a[4k+3:4k], alu_b = b[4k+3:4k], alu_ctrl = captured op.
    - alu_cin = captured cin at k=0, else the stored carry from the previous pass, for op 000 (add).
    - alu_cin = 0 for all other ops.
    - At the clock edge, alu_out is written to result[4k+3:4k] and alu_cout is stored. After k = NIB-1 -> RESP.
  - RESP: resp_valid = 1 for exactly 1 cycle, along with resp_id, resp_data, resp_cout and resp_err. Next state is IDLE.
  - No new grant is issued in RESP. The earliest next ready is in the following IDLE cycle.
- Latency: ready at cycle T; resp_valid at T+NIB+1; throughput is one operation per NIB+2 cycles.
- alu_* outputs are 0 outside EXEC.
- resp_data, resp_id, resp_cout and resp_err hold their values after RESP until the next RESP. Only resp_valid qualifies them.
- Supported opcodes:
  - 000 add: carry chained; resp_cout = alu_cout of the last pass.
  - 010 OR and 011 AND: resp_cout = 0.
- There is no response backpressure. The consumer must take the data on resp_valid.
- A requester that changes its fields while valid and not ready is a protocol violation; the sampled values are whatever is present on the grant cycle.

Optional Feature:
- Macro: ALU_SEQ_ERR_EN.
- Defined: opcodes other than 000/010/011 skip EXEC and go from IDLE straight to RESP the cycle after the grant.
  - The response carries resp_err = 1, resp_data = 0 and resp_cout = 0; latency is T+1.
- Undefined: all opcodes run through EXEC unchanged with carry chaining disabled, and resp_err is tied to 0.

Test Plan:
- After rst, req0 add a=0x3C b=0x5A cin=0 -> req0_ready once, resp_valid 3 cycles later, resp_data=0x96, resp_cout=0, resp_id=0.
- req1 add a=0xF0 b=0x20 cin=1 -> resp_data=0x11, resp_cout=1. The low pass has alu_cin=1; the high pass has alu_cin=0 (carry out of 0x0+0x0+1 is 0).
- req0 OR a=0xA5 b=0x0F -> resp_data=0xAF, resp_cout=0. Then AND with the same operands -> resp_data=0x05.
- req0 and req1 both valid continuously with add ops -> grants alternate 0,1,0,1. Each ready is 4 cycles apart, and never both in one cycle.
- rst asserted during EXEC k=1 -> no resp_valid. State is IDLE next cycle; a held req0_valid is re-granted after rst is deasserted.
- With ALU_SEQ_ERR_EN defined, req1 op=3'b101 -> resp_valid the cycle after ready, resp_err=1, resp_data=0x00. With it undefined -> normal 3-cycle latency and resp_err=0.
